// File: rtl/frac_divider_if.sv
// Handshake and operand/result bundle for frac_divider.
// The master starts divisions; the slave (the divider) returns results and status.
interface frac_divider_if #(
    parameter int DW = 16,
    parameter int QW = 8
);
    logic          en;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divider;
    logic [QW-1:0] quotient;
    logic          busy;
    logic          done;
    logic          sat;
    logic          dbz;

    modport master (
        output en, dividend, divider,
        input  quotient, busy, done, sat, dbz
    );

    modport slave (
        input  en, dividend, divider,
        output quotient, busy, done, sat, dbz
    );
endinterface

// File: rtl/frac_divider.sv
// Multi-cycle restoring fractional divider: quotient = floor(dividend * 2^QW / divider),
// saturating, with optional round-half-up, zero-divisor flag and busy/done handshake.
module frac_divider #(
    parameter int DW    = 16,
    parameter int QW    = 8,
    parameter int ROUND = 0
) (
    input logic          clk,
    input logic          nrst,
    frac_divider_if.slave bus
);
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {IDLE, CALC, RND} state_t;

    state_t        state_q, state_d;
    logic [DW:0]   rem_q, rem_d;
    logic [DW-1:0] d_q, d_d;
    logic [QW-1:0] q_acc_q, q_acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] quotient_q, quotient_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sat_q, sat_d;
    logic          dbz_q, dbz_d;

    logic          div_zero;
    logic          fast_sat;
    logic          last_step;
    logic [DW:0]   t;
    logic [DW:0]   d_ext;
    logic          t_ge;

    // Increment with saturation: returns {overflowed, value}, pinning the value at all-ones.
    function automatic logic [QW:0] round_sat(input logic [QW-1:0] q, input logic up);
        logic [QW:0] sum;
        sum = {1'b0, q} + (QW+1)'(up);
        if (sum[QW]) sum = {1'b1, {QW{1'b1}}};
        return sum;
    endfunction

    assign div_zero  = (bus.divider == '0);
    assign fast_sat  = (bus.dividend >= bus.divider);
    assign last_step = (cnt_q == CW'(1));
    // rem < d_q always holds, so the shifted remainder never loses its top bit.
    assign t         = rem_q << 1;
    assign d_ext     = {1'b0, d_q};
    assign t_ge      = (t >= d_ext);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            d_q        <= '0;
            q_acc_q    <= '0;
            cnt_q      <= '0;
            quotient_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            d_q        <= d_d;
            q_acc_q    <= q_acc_d;
            cnt_q      <= cnt_d;
            quotient_q <= quotient_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sat_q      <= sat_d;
            dbz_q      <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en && !div_zero && !fast_sat) state_d = CALC;
            CALC:    if (last_step) state_d = (ROUND != 0) ? RND : IDLE;
            RND:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_d      = rem_q;
        d_d        = d_q;
        q_acc_d    = q_acc_q;
        cnt_d      = cnt_q;
        quotient_d = quotient_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sat_d      = sat_q;
        dbz_d      = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    d_d = bus.divider;
                    if (div_zero) begin
                        quotient_d = '1;
                        dbz_d      = 1'b1;
                        sat_d      = 1'b0;
                        done_d     = 1'b1;
                    end else if (fast_sat) begin
                        quotient_d = '1;
                        sat_d      = 1'b1;
                        dbz_d      = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        rem_d   = {1'b0, bus.dividend};
                        q_acc_d = '0;
                        cnt_d   = CW'(QW);
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                rem_d   = t_ge ? (t - d_ext) : t;
                q_acc_d = (q_acc_q << 1) | QW'(t_ge);
                cnt_d   = cnt_q - CW'(1);
                if (last_step && (ROUND == 0)) begin
                    quotient_d = q_acc_d;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    sat_d      = 1'b0;
                    dbz_d      = 1'b0;
                end
            end
            RND: begin
                // Here t is twice the final remainder: round up when it reaches the divisor.
                {sat_d, quotient_d} = round_sat(q_acc_q, t_ge);
                dbz_d  = 1'b0;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.quotient = quotient_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sat      = sat_q;
    assign bus.dbz      = dbz_q;
endmodule

// File: tb/tb_frac_divider.sv
// Bench for frac_divider: truncating and rounding instances checked against
// a plain-arithmetic reference with directed and randomised operands.
module tb_frac_divider;
    localparam int DW = 16;
    localparam int QW = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    frac_divider_if #(.DW(DW), .QW(QW)) if0 ();
    frac_divider_if #(.DW(DW), .QW(QW)) if1 ();

    frac_divider #(.DW(DW), .QW(QW), .ROUND(0)) u0 (.clk(clk), .nrst(nrst), .bus(if0));
    frac_divider #(.DW(DW), .QW(QW), .ROUND(1)) u1 (.clk(clk), .nrst(nrst), .bus(if1));

    int tests = 0;
    int fails = 0;
    logic [7:0] last_q [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: {sat, dbz, quotient} from exact integer division.
    function automatic logic [9:0] ref_div(input logic [15:0] a, input logic [15:0] b, input bit rnd);
        longint num, q, r;
        if (b == 0) return {1'b0, 1'b1, 8'hFF};
        if (a >= b) return {1'b1, 1'b0, 8'hFF};
        num = longint'(a) * 256;
        q = num / longint'(b);
        r = num % longint'(b);
        if (rnd && (2 * r >= longint'(b))) q++;
        if (q > 255) return {1'b1, 1'b0, 8'hFF};
        return {2'b00, 8'(q)};
    endfunction

    // {busy, done, sat, dbz, quotient}
    function automatic logic [11:0] get(input int i);
        if (i == 0) return {if0.busy, if0.done, if0.sat, if0.dbz, if0.quotient};
        return {if1.busy, if1.done, if1.sat, if1.dbz, if1.quotient};
    endfunction

    task automatic set_in(input int i, input logic e, input logic [15:0] a, input logic [15:0] b);
        if (i == 0) begin
            if0.en = e; if0.dividend = a; if0.divider = b;
        end else begin
            if1.en = e; if1.dividend = a; if1.divider = b;
        end
    endtask

    task automatic do_div(input int i, input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [9:0]  e;
        logic [11:0] s;
        int n, exp_lat;
        bit hold_ok;
        e = ref_div(a, b, i == 1);
        exp_lat = (b == 0 || a >= b) ? 0 : ((i == 1) ? QW + 1 : QW);
        @(negedge clk);
        set_in(i, 1'b1, a, b);
        @(negedge clk);
        set_in(i, 1'b0, a, b);
        s = get(i);
        check({tag, ".busy"}, 32'(s[11]), 32'(exp_lat > 0));
        n = 0;
        hold_ok = 1'b1;
        while (s[10] !== 1'b1 && n < 40) begin
            if (s[7:0] !== last_q[i]) hold_ok = 1'b0;
            @(negedge clk);
            n++;
            s = get(i);
        end
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        check({tag, ".result"}, 32'(s[9:0]), 32'(e));
        check({tag, ".hold"}, 32'(hold_ok), 32'd1);
        last_q[i] = e[7:0];
        @(negedge clk);
        s = get(i);
        check({tag, ".pulse"}, 32'({s[11], s[10]}), 32'd0);
    endtask

    initial begin
        logic [11:0] s;
        logic [15:0] a, b;
        int dones, first, prev, sel;
        bit iv_ok;
        logic [7:0] qv;

        last_q[0] = 8'd0;
        last_q[1] = 8'd0;
        set_in(0, 1'b0, 16'd1, 16'd1);
        set_in(1, 1'b0, 16'd1, 16'd1);
        nrst = 1'b0;
        #1;
        check("rst.u0", 32'(get(0)), 32'd0);
        check("rst.u1", 32'(get(1)), 32'd0);
        @(posedge clk);
        #1;
        check("rst_edge.u0", 32'(get(0)), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("rst_rel.u0", 32'(get(0)), 32'd0);
        check("rst_rel.u1", 32'(get(1)), 32'd0);

        // Directed, truncating instance
        do_div(0, 16'd22000, 16'd22727, "t22000");
        check("t22000.q247", 32'(if0.quotient), 32'd247);
        do_div(0, 16'd22256, 16'd22727, "t22256");
        check("t22256.q250", 32'(if0.quotient), 32'd250);
        do_div(0, 16'd22727, 16'd22727, "eq");
        do_div(0, 16'd0, 16'd22727, "zero_num");
        do_div(0, 16'd1234, 16'd0, "dbz");
        check("dbz.flag", 32'(if0.dbz), 32'd1);

        // Directed, rounding instance
        do_div(1, 16'd1, 16'd3, "r1_3");
        check("r1_3.q85", 32'(if1.quotient), 32'd85);
        do_div(1, 16'd2, 16'd3, "r2_3");
        check("r2_3.q171", 32'(if1.quotient), 32'd171);
        do_div(1, 16'd22726, 16'd22727, "r_ovf");
        check("r_ovf.sat", 32'(if1.sat), 32'd1);

        // Randomised operands on both instances
        for (int k = 0; k < 32; k++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0) begin
                b = 16'd0; a = 16'($urandom_range(0, 65535));
            end else if (sel == 1) begin
                b = 16'($urandom_range(1, 65535)); a = 16'($urandom_range(int'(b), 65535));
            end else begin
                b = 16'($urandom_range(1, 65535)); a = 16'($urandom_range(0, int'(b) - 1));
            end
            do_div(k % 2, a, b, $sformatf("rand%0d", k));
        end

        // Second en while busy must be ignored
        @(negedge clk);
        set_in(0, 1'b1, 16'd1000, 16'd3000);
        @(negedge clk);
        set_in(0, 1'b0, 16'd1000, 16'd3000);
        dones = 0;
        qv = 8'd0;
        for (int c = 0; c < 25; c++) begin
            if (c == 2) set_in(0, 1'b1, 16'd5, 16'd7);
            if (c == 3) set_in(0, 1'b0, 16'd5, 16'd7);
            s = get(0);
            if (s[10]) begin
                dones++;
                qv = s[7:0];
            end
            @(negedge clk);
        end
        check("ign.dones", 32'(dones), 32'd1);
        check("ign.q", 32'(qv), 32'(ref_div(16'd1000, 16'd3000, 1'b0) & 10'hFF));
        last_q[0] = qv;

        // en held high: back-to-back restarts every QW+1 cycles
        @(negedge clk);
        set_in(0, 1'b1, 16'd100, 16'd200);
        dones = 0; first = -1; prev = -1; iv_ok = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            s = get(0);
            if (s[10]) begin
                if (prev >= 0 && (c - prev) != QW + 1) iv_ok = 1'b0;
                if (first < 0) first = c;
                prev = c;
                dones++;
            end
        end
        set_in(0, 1'b0, 16'd100, 16'd200);
        repeat (12) @(negedge clk);
        check("held.dones", 32'(dones), 32'd3);
        check("held.first", 32'(first), 32'(QW));
        check("held.interval", 32'(iv_ok), 32'd1);
        check("held.q", 32'(if0.quotient), 32'd128);
        last_q[0] = 8'd128;

        // Reset in the middle of a division
        @(negedge clk);
        set_in(0, 1'b1, 16'd22000, 16'd22727);
        @(negedge clk);
        set_in(0, 1'b0, 16'd22000, 16'd22727);
        repeat (3) @(negedge clk);
        check("mid.busy_before", 32'(if0.busy), 32'd1);
        nrst = 1'b0;
        #1;
        check("mid.rst", 32'({if0.quotient, if0.busy, if0.done}), 32'd0);
        last_q[0] = 8'd0;
        last_q[1] = 8'd0;
        @(negedge clk);
        nrst = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (if0.done) dones++;
        end
        check("mid.no_done", 32'(dones), 32'd0);
        check("mid.q0", 32'(if0.quotient), 32'd0);
        do_div(0, 16'd100, 16'd200, "after_rst");
        check("after_rst.q128", 32'(if0.quotient), 32'd128);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
